key_debounce8: RTL and testbench
================================

Name: key_debounce8

Overview:
- Conditions eight raw mechanical key/switch inputs into clean, glitch-free levels.
- The key_level outputs drive the 8-input priority encoder's in1..in8 directly: key_level[0] to in1, through key_level[7] to in8.
- Also provides per-key press/release pulses and an any-key flag for downstream control logic.
- Each channel has a 2-flop synchronizer followed by an independent counter-based debouncer.

Parameters:
- DB_CYCLES, default 4: consecutive mismatching synchronized samples required before a channel's level changes. Legal range 1..2^CNT_W.
- CNT_W, default 4: width of each per-channel debounce counter. Must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- key_raw, input, 8: asynchronous raw key inputs, active-high.
- key_level, output, 8: debounced key levels; bit i feeds encoder input in(i+1).
- key_press, output, 8: one-cycle pulse on a debounced 0->1 transition of bit i.
- key_release, output, 8: one-cycle pulse on a debounced 1->0 transition of bit i.
- key_any, output, 1: OR of key_level; tells the encoder consumer that its code is valid (the encoder output is high-Z when no input is active).

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously clears all sync flops, counters, key_level, key_press and key_release to 0, so key_any = 0.
  - Release of reset is synchronous to clk.
  - Reset asserted mid-debounce discards the count; no pulse is emitted.
- Synchronizer: per bit, sync1 <= key_raw, then sync2 <= sync1. No logic between the two stages.
- Debounce, per channel i, evaluated every rising edge:
  - If sync2[i] == key_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: key_level[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a raw level first sampled at edge k, and held, appears on key_level after edge k+1+DB_CYCLES.
  - For DB_CYCLES=4 that is 6 edges after first sampling, counting edge k.
- Glitch rejection: any return of sync2[i] to key_level[i] before the count completes resets cnt[i] to 0 and leaves key_level unchanged.
  - A bounce train whose high runs are each shorter than DB_CYCLES synchronized cycles produces no transition.
- Pulses:
  - key_press[i] and key_release[i] are registered, 0 by default.
  - key_press[i] is 1 for exactly the one cycle following the edge at which key_level[i] rises.
  - key_release[i] follows the same rule on a fall.
  - Never both 1 on the same bit in the same cycle.
- Channel independence: channels are independent. Simultaneous transitions on multiple bits update in the same cycle and pulse together. No cross-channel priority is applied here; priority is the encoder's job.
- key_any is combinational from the key_level registers (glitch-free, since only registers feed it).
- DB_CYCLES=1: key_level follows sync2 with one extra edge; no filtering.
- Counter wrap cannot occur, because cnt is cleared at DB_CYCLES-1. A parameter combination violating 2^CNT_W >= DB_CYCLES is illegal; an elaboration-time check halts simulation.

Test Plan (DB_CYCLES=4, CNT_W=4):
- Reset check: rst_n=0 with key_raw=8'hFF -> key_level=8'h00, key_press=8'h00, key_release=8'h00, key_any=0 throughout reset.
- Clean press: key_raw 8'h00->8'h04 before edge 0, held -> key_level=8'h04 after edge 5; key_press=8'h04 for exactly one cycle; key_any=1; encoder output = 3'h2.
- Bounce rejection: key_raw[0] toggles 1,0 every 2 cycles for 20 cycles, then stays 0 -> key_level[0]=0 throughout, no key_press or key_release.
- Multi-key and priority feed: key_raw=8'h0A held -> key_level=8'h0A with key_press=8'h0A in the same cycle; encoder output = 3'h1. Then key_raw=8'h08 -> after latency key_release=8'h02 for one cycle, key_level=8'h08, encoder output = 3'h3.
- Release and idle: key_raw returns to 8'h00 -> key_release pulses once; key_level=8'h00, key_any=0 after edge k+5.
- Reset mid-count: assert rst_n at edge 3 of a press count, release it, keep key_raw=8'h01 -> the count restarts; key_level[0] rises 6 edges after reset release; no stale pulse.

Source files
------------

// File: rtl/key_debounce8_if.sv
// Signal bundle between the eight-key debouncer and its consumers.
// The debouncer side is the master; the raw key source and downstream logic use the slave view.
interface key_debounce8_if;
  logic [7:0] key_raw;
  logic [7:0] key_level;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic       key_any;

  modport master (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_any
  );

  modport slave (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_any
  );
endinterface

// File: rtl/key_debounce8.sv
// Eight-channel key conditioner: 2-flop synchronizer plus counter debouncer per key.
// key_level feeds the priority encoder directly; press/release pulses and key_any serve control logic.
module key_debounce8 #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  key_debounce8_if.master kb
);

  if (DB_CYCLES < 1 || (2 ** CNT_W) < DB_CYCLES) begin : g_param_check
    $fatal(1, "key_debounce8: DB_CYCLES must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_CYCLES - 1);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] level_q;
  logic [7:0] press_q;
  logic [7:0] release_q;

  // Plain two-stage synchronizer; nothing may sit between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= kb.key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;

    // Any agreement with the current level restarts the count, so short bounces never commit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        if (sync2[i] == level) begin
          cnt <= '0;
        end else if (cnt == LAST_CNT) begin
          cnt   <= '0;
          level <= sync2[i];
          press <= sync2[i];
          rel   <= ~sync2[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign level_q[i]   = level;
    assign press_q[i]   = press;
    assign release_q[i] = rel;
  end

  assign kb.key_level   = level_q;
  assign kb.key_press   = press_q;
  assign kb.key_release = release_q;
  assign kb.key_any     = |level_q;

endmodule

// File: tb/tb_key_debounce8.sv
// Directed bench for key_debounce8 with DB_CYCLES=4: latency, bounce rejection, multi-key and reset.
module tb_key_debounce8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  key_debounce8_if kb ();

  key_debounce8 #(.DB_CYCLES(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kb    (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoder consumer model: in1 (key_level[0]) has the highest priority.
  function automatic logic [7:0] enc8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 8'(i);
    end
    return 8'h00;
  endfunction

  task automatic applyStimulus(input logic [7:0] raw);
    @(negedge clk);
    kb.key_raw = raw;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] lvl, input logic [7:0] prs,
                          input logic [7:0] rls);
    checkOutput({tag, "_level"}, kb.key_level, lvl);
    checkOutput({tag, "_press"}, kb.key_press, prs);
    checkOutput({tag, "_release"}, kb.key_release, rls);
    checkOutput({tag, "_any"}, {7'b0, kb.key_any}, {7'b0, |lvl});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    kb.key_raw  = 8'hFF;

    // Reset holds everything low even with all keys pressed.
    for (int c = 0; c < 4; c++) begin
      waitEdges(1);
      checkAll("reset", 8'h00, 8'h00, 8'h00);
    end
    applyStimulus(8'h00);
    rst_n = 1'b1;
    waitEdges(3);
    checkAll("post_reset", 8'h00, 8'h00, 8'h00);

    // Clean press of key 2: level rises after edge 5.
    applyStimulus(8'h04);
    waitEdges(5);
    checkAll("press_edge4", 8'h00, 8'h00, 8'h00);
    waitEdges(1);
    checkAll("press_edge5", 8'h04, 8'h04, 8'h00);
    checkOutput("press_enc", enc8(kb.key_level), 8'h02);
    waitEdges(1);
    checkAll("press_edge6", 8'h04, 8'h00, 8'h00);

    // Release key 2.
    applyStimulus(8'h00);
    waitEdges(5);
    checkAll("rel_edge4", 8'h04, 8'h00, 8'h00);
    waitEdges(1);
    checkAll("rel_edge5", 8'h00, 8'h00, 8'h04);
    waitEdges(1);
    checkAll("rel_edge6", 8'h00, 8'h00, 8'h00);

    // Bounce on key 0: runs of 2 cycles never reach the 4-cycle count.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(((c / 2) % 2 == 0) ? 8'h01 : 8'h00);
      waitEdges(1);
      checkAll("bounce", 8'h00, 8'h00, 8'h00);
    end
    for (int c = 0; c < 8; c++) begin
      waitEdges(1);
      checkAll("bounce_tail", 8'h00, 8'h00, 8'h00);
    end

    // Two keys at once commit and pulse together; in2 wins the encoder.
    applyStimulus(8'h0A);
    waitEdges(5);
    checkAll("multi_edge4", 8'h00, 8'h00, 8'h00);
    waitEdges(1);
    checkAll("multi_edge5", 8'h0A, 8'h0A, 8'h00);
    checkOutput("multi_enc", enc8(kb.key_level), 8'h01);
    waitEdges(1);
    checkAll("multi_edge6", 8'h0A, 8'h00, 8'h00);

    // Drop key 1 only; key 3 stays and takes the encoder.
    applyStimulus(8'h08);
    waitEdges(5);
    checkAll("drop_edge4", 8'h0A, 8'h00, 8'h00);
    waitEdges(1);
    checkAll("drop_edge5", 8'h08, 8'h00, 8'h02);
    checkOutput("drop_enc", enc8(kb.key_level), 8'h03);
    waitEdges(1);
    checkAll("drop_edge6", 8'h08, 8'h00, 8'h00);

    // Back to idle.
    applyStimulus(8'h00);
    waitEdges(5);
    checkAll("idle_edge4", 8'h08, 8'h00, 8'h00);
    waitEdges(1);
    checkAll("idle_edge5", 8'h00, 8'h00, 8'h08);
    waitEdges(1);
    checkAll("idle_edge6", 8'h00, 8'h00, 8'h00);

    // Reset in the middle of a press count discards it; the count restarts afterwards.
    applyStimulus(8'h01);
    waitEdges(4);
    rst_n = 1'b0;
    #1;
    checkAll("midrst_in", 8'h00, 8'h00, 8'h00);
    waitEdges(2);
    checkAll("midrst_hold", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      waitEdges(1);
      checkAll("midrst_count", 8'h00, 8'h00, 8'h00);
    end
    waitEdges(1);
    checkAll("midrst_rise", 8'h01, 8'h01, 8'h00);
    waitEdges(1);
    checkAll("midrst_after", 8'h01, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
